// File: rtl/scan_select_ctrl_pkg.sv
// Shared types and helpers for the decoder scan controller.
// Channel stepping is modulo NUM_CH; a wrap is flagged on the 7->0 or 0->7 step.
package scan_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned NUM_CH = 8;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  typedef struct packed {
    logic             wrap;
    logic [SEL_W-1:0] ch;
  } step_t;

  function automatic step_t advance_ch(input logic [SEL_W-1:0] ch, input logic dir);
    step_t s;
    if (dir) begin
      s.ch   = ch - 1'b1;
      s.wrap = (ch == '0);
    end else begin
      s.ch   = ch + 1'b1;
      s.wrap = (ch == '1);
    end
    return s;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module dwell_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/scan_select_ctrl.sv
// Round-robin scan front end for a 3-to-8 decoder: BLANK gap, then SHOW for
// a sampled dwell, then advance the channel. Outputs are all registered.
module scan_select_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_W      = 8,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               load,
  input  logic [SEL_W-1:0]   load_sel,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  output logic               x,
  output logic               y,
  output logic               z,
  output logic               enable,
  output logic               busy,
  output logic               wrap
);

  localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYCLES - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic               wrap_d;
  step_t              nxt;
  logic               blank_load, blank_dec, blank_zero;
  logic               dwell_load, dwell_dec, dwell_zero;
  logic [DWELL_W-1:0] dwell_last;

  // Counter holds D-1 so the zero flag marks the final SHOW cycle; dwell 0 acts as 1.
  assign dwell_last = (dwell == '0) ? '0 : dwell - 1'b1;
  assign nxt        = advance_ch(ch_q, dir);

  dwell_counter #(.W(4)) u_blank_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (blank_load),
    .load_val (BLANK_LAST),
    .dec      (blank_dec),
    .zero     (blank_zero)
  );

  dwell_counter #(.W(DWELL_W)) u_dwell_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dwell_load),
    .load_val (dwell_last),
    .dec      (dwell_dec),
    .zero     (dwell_zero)
  );

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    wrap_d     = 1'b0;
    blank_load = 1'b0;
    blank_dec  = 1'b0;
    dwell_load = 1'b0;
    dwell_dec  = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) ch_d = load_sel;
          if (start) begin
            state_d    = BLANK;
            blank_load = 1'b1;
          end
        end
        BLANK: begin
          if (blank_zero) begin
            state_d    = SHOW;
            dwell_load = 1'b1;
          end else begin
            blank_dec = 1'b1;
          end
        end
        SHOW: begin
          if (dwell_zero) begin
            ch_d       = nxt.ch;
            wrap_d     = nxt.wrap;
            state_d    = BLANK;
            blank_load = 1'b1;
          end else begin
            dwell_dec = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      enable  <= 1'b0;
      busy    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      enable  <= (state_d == SHOW);
      busy    <= (state_d != IDLE);
      wrap    <= wrap_d;
    end
  end

  assign x = ch_q[2];
  assign y = ch_q[1];
  assign z = ch_q[0];

endmodule

// File: tb/tb_scan_select_ctrl.sv
// Self-checking bench for scan_select_ctrl against a period-position model.
module tb_scan_select_ctrl;

  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, load = 1'b0, dir = 1'b0;
  logic [2:0] load_sel = '0;
  logic [7:0] dwell = 8'd1;
  logic       x, y, z, enable, busy, wrap;
  logic [5:0] obs;

  int n_vec = 0;
  int n_err = 0;

  // Model: position m_r within the current channel period (BLANK is 0..B-1,
  // SHOW is B..B+D-1), channel as an integer, D captured on entering SHOW.
  int m_ch = 0, m_r = 0, m_D = 1;
  bit m_busy = 0, m_wrap = 0;

  scan_select_ctrl #(.DWELL_W(8), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
    .load_sel(load_sel), .dir(dir), .dwell(dwell),
    .x(x), .y(y), .z(z), .enable(enable), .busy(busy), .wrap(wrap)
  );

  assign obs = {x, y, z, enable, busy, wrap};

  always #5 clk = ~clk;

  function automatic logic [5:0] exp_vec();
    return {3'(m_ch), (m_busy && m_r >= B), m_busy, m_wrap};
  endfunction

  function automatic void model_reset();
    m_ch = 0; m_r = 0; m_D = 1; m_busy = 0; m_wrap = 0;
  endfunction

  function automatic void model_edge();
    m_wrap = 0;
    if (stop) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (load) m_ch = int'(load_sel);
      if (start) begin
        m_busy = 1;
        m_r = 0;
      end
    end else if (m_r == B - 1) begin
      m_D = (dwell == 0) ? 1 : int'(dwell);
      m_r++;
    end else if (m_r == B + m_D - 1) begin
      m_wrap = dir ? (m_ch == 0) : (m_ch == 7);
      m_ch = (m_ch + (dir ? 7 : 1)) % 8;
      m_r = 0;
    end else begin
      m_r++;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic go_idle();
    stop = 1; start = 0; load = 0;
    tick();
    stop = 0;
  endtask

  task automatic test_reset();
    int j;
    #12 rst_n = 1;
    #1;
    n_vec++;
    if (obs !== 6'b0) begin
      n_err++; $display("FAIL reset_state: got %b want 000000", obs);
    end
    load = 1; load_sel = 3'd5; start = 1; dwell = 8'd4; dir = 0;
    tick();
    load = 0; start = 0;
    j = 0;
    while (!(m_busy && m_r >= B && m_ch == 5) && j < 60) begin
      tick(); j++;
    end
    n_vec++;
    if (obs !== exp_vec() || !enable) begin
      n_err++; $display("FAIL reset_reach_show: got %b want %b", obs, exp_vec());
    end
    #2 rst_n = 0;
    #1;
    n_vec++;
    if (obs !== 6'b0) begin
      n_err++; $display("FAIL async_reset: got %b want 000000", obs);
    end
    model_reset();
    #2 rst_n = 1;
  endtask

  task automatic test_ascending();
    int wraps = 0, first_en = -1, ch_at5 = -1;
    load = 1; load_sel = 0; start = 1; dwell = 8'd3; dir = 0;
    tick();
    load = 0; start = 0;
    for (int j = 1; j <= 40; j++) begin
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL asc j=%0d: got %b want %b", j, obs, exp_vec());
      end
      if (wrap) wraps++;
      if (enable && first_en < 0) first_en = j;
      if (j == 5) ch_at5 = int'({x, y, z});
    end
    n_vec++;
    if (first_en != 2) begin
      n_err++; $display("FAIL asc_first_enable: got %0d want 2", first_en);
    end
    n_vec++;
    if (ch_at5 != 1) begin
      n_err++; $display("FAIL asc_ch1_time: got %0d want 1", ch_at5);
    end
    n_vec++;
    if (wraps != 1 || {x, y, z} !== 3'd0) begin
      n_err++; $display("FAIL asc_loop: got wraps=%0d ch=%0d want wraps=1 ch=0", wraps, {x, y, z});
    end
    go_idle();
  endtask

  task automatic test_descending_load();
    int seq[$];
    int wraps = 0;
    logic prev_en = 0;
    load = 1; load_sel = 3'd6; start = 1; dwell = 8'd1; dir = 1;
    tick();
    load = 0; start = 0;
    for (int j = 1; j <= 24; j++) begin
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL desc j=%0d: got %b want %b", j, obs, exp_vec());
      end
      if (enable && !prev_en) seq.push_back(int'({x, y, z}));
      if (wrap) wraps++;
      prev_en = enable;
    end
    n_vec++;
    if (seq.size() != 8) begin
      n_err++; $display("FAIL desc_count: got %0d want 8", seq.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_vec++;
        if (seq[k] != (14 - k) % 8) begin
          n_err++; $display("FAIL desc_seq[%0d]: got %0d want %0d", k, seq[k], (14 - k) % 8);
        end
      end
    end
    n_vec++;
    if (wraps != 1) begin
      n_err++; $display("FAIL desc_wrap: got %0d want 1", wraps);
    end
    go_idle();
  endtask

  task automatic test_dwell_zero();
    int en_cycles = 0;
    load = 1; load_sel = 0; start = 1; dwell = 8'd0; dir = 0;
    tick();
    load = 0; start = 0;
    for (int j = 1; j <= 24; j++) begin
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL dwell0 j=%0d: got %b want %b", j, obs, exp_vec());
      end
      if (enable) en_cycles++;
    end
    n_vec++;
    if (en_cycles != 8) begin
      n_err++; $display("FAIL dwell0_count: got %0d want 8", en_cycles);
    end
    go_idle();
  endtask

  task automatic test_stop_on_expiry();
    int j = 0;
    int first_ch = -1;
    load = 1; load_sel = 3'd3; start = 1; dwell = 8'd2; dir = 0;
    tick();
    load = 0; start = 0;
    while (!(m_busy && m_ch == 3 && m_r == B + m_D - 1) && j < 40) begin
      tick(); j++;
    end
    n_vec++;
    if (!enable || {x, y, z} !== 3'd3 || j >= 40) begin
      n_err++; $display("FAIL stop_setup: got en=%b ch=%0d want en=1 ch=3", enable, {x, y, z});
    end
    stop = 1;
    tick();
    stop = 0;
    n_vec++;
    if (obs !== {3'd3, 3'b000}) begin
      n_err++; $display("FAIL stop_expiry: got %b want 011000", obs);
    end
    start = 1;
    tick();
    start = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL resume k=%0d: got %b want %b", k, obs, exp_vec());
      end
      if (enable && first_ch < 0) first_ch = int'({x, y, z});
    end
    n_vec++;
    if (first_ch != 3) begin
      n_err++; $display("FAIL resume_ch: got %0d want 3", first_ch);
    end
    go_idle();
  endtask

  task automatic test_busy_ignore();
    int c0;
    c0 = $urandom_range(0, 7);
    load = 1; load_sel = 3'(c0); start = 1; dwell = 8'd2; dir = 0;
    tick();
    for (int j = 1; j <= 30; j++) begin
      start = ($urandom_range(0, 2) == 0);
      load = ($urandom_range(0, 2) == 0);
      load_sel = 3'($urandom);
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL busy_ign j=%0d: got %b want %b", j, obs, exp_vec());
      end
    end
    start = 0; load = 0;
    n_vec++;
    if (int'({x, y, z}) != (c0 + 7) % 8) begin
      n_err++; $display("FAIL busy_ign_ch: got %0d want %0d", {x, y, z}, (c0 + 7) % 8);
    end
    go_idle();
  endtask

  task automatic test_dwell_change();
    int en0 = 0, en1 = 0;
    load = 1; load_sel = 0; start = 1; dwell = 8'd4; dir = 0;
    tick();
    load = 0; start = 0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL dchg j=%0d: got %b want %b", j, obs, exp_vec());
      end
      if (enable && {x, y, z} == 3'd0) begin
        en0++;
        dwell = 8'd2;
      end
      if (enable && {x, y, z} == 3'd1) en1++;
    end
    n_vec++;
    if (en0 != 4 || en1 != 2) begin
      n_err++; $display("FAIL dchg_counts: got %0d/%0d want 4/2", en0, en1);
    end
    go_idle();
  endtask

  task automatic test_random();
    for (int j = 0; j < 400; j++) begin
      stop = ($urandom_range(0, 19) == 0);
      start = ($urandom_range(0, 7) == 0);
      load = ($urandom_range(0, 7) == 0);
      load_sel = 3'($urandom);
      dir = 1'($urandom);
      dwell = 8'($urandom_range(0, 4));
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL rand j=%0d: got %b want %b", j, obs, exp_vec());
      end
    end
    go_idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ascending();
    test_descending_load();
    test_dwell_zero();
    test_stop_on_expiry();
    test_busy_ignore();
    test_dwell_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
